// File: rtl/fb_write_arbiter_pkg.sv
// Shared constants and types for the framebuffer write arbiter.
//  - Frame geometry (WIDTH x HEIGHT), pixel and address widths.
//  - Fill FSM state encodings kept as plain localparam constants.
//  - Arbiter owner enum and a clip helper used when a fill command is set up.
package fb_write_arbiter_pkg;

    localparam int WIDTH     = 1280;
    localparam int HEIGHT    = 720;
    localparam int DATA_W    = 24;
    localparam int XY_W      = 12;
    localparam int FB_PIXELS = WIDTH * HEIGHT;
    localparam int ADDR_W    = $clog2(FB_PIXELS);

    // Limits widened by one bit so x+w / y+h sums cannot overflow.
    localparam logic [XY_W:0]   WIDTH_E  = (XY_W+1)'(WIDTH);
    localparam logic [XY_W:0]   HEIGHT_E = (XY_W+1)'(HEIGHT);
    localparam logic [XY_W-1:0] XY_ONE   = XY_W'(1);
    localparam logic [XY_W-1:0] XY_ZERO  = XY_W'(0);

    typedef logic [DATA_W-1:0] pixel_t;

    typedef logic [1:0] fill_state_e;
    localparam fill_state_e ST_IDLE  = 2'd0;
    localparam fill_state_e ST_SETUP = 2'd1;
    localparam fill_state_e ST_FILL  = 2'd2;
    localparam fill_state_e ST_DONE  = 2'd3;

    typedef enum logic {
        OWNER_HOST = 1'b0,
        OWNER_FILL = 1'b1
    } arb_owner_e;

    // Exclusive end coordinate of a span, clipped to the frame limit.
    function automatic logic [XY_W:0] clip_end(input logic [XY_W-1:0] start,
                                               input logic [XY_W-1:0] size,
                                               input logic [XY_W:0]   limit);
        logic [XY_W:0] sum;
        sum = {1'b0, start} + {1'b0, size};
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/fb_rect_walker.sv
// Rectangle walker for the fill engine.
//  load_i     : capture fill_x/y/w/h (fill command accepted)
//  setup_i    : clip the captured rectangle and arm the walk
//  advance_i  : current pixel was granted; step to the next one
//  empty_o    : captured rectangle clips to zero pixels
//  walk_valid_o / walk_addr_o / walk_last_o : current pixel and last-pixel flag
// The walk keeps a running row base (+WIDTH per row) so no multiplier sits
// in the per-pixel path; the only multiply happens once in setup.
module fb_rect_walker
    import fb_write_arbiter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [XY_W-1:0]   fill_x_i,
    input  logic [XY_W-1:0]   fill_y_i,
    input  logic [XY_W-1:0]   fill_w_i,
    input  logic [XY_W-1:0]   fill_h_i,
    input  logic              setup_i,
    input  logic              advance_i,
    output logic              empty_o,
    output logic              walk_valid_o,
    output logic [ADDR_W-1:0] walk_addr_o,
    output logic              walk_last_o
);

    logic [XY_W-1:0]   x_q, y_q, w_q, h_q, col_q, row_q;
    logic [XY_W-1:0]   x_d, y_d, w_d, h_d, col_d, row_d;
    logic [XY_W:0]     x_end_q, y_end_q, x_end_d, y_end_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              active_q, active_d;

    logic [XY_W:0]     x_end_s, y_end_s;
    logic              empty_s, row_end_s, last_s;

    assign x_end_s   = clip_end(x_q, w_q, WIDTH_E);
    assign y_end_s   = clip_end(y_q, h_q, HEIGHT_E);
    assign empty_s   = (w_q == XY_ZERO) || (h_q == XY_ZERO) ||
                       ({1'b0, x_q} >= WIDTH_E) || ({1'b0, y_q} >= HEIGHT_E);
    assign row_end_s = ({1'b0, col_q} + (XY_W+1)'(1)) == x_end_q;
    assign last_s    = row_end_s && (({1'b0, row_q} + (XY_W+1)'(1)) == y_end_q);

    assign empty_o      = empty_s;
    assign walk_valid_o = active_q;
    assign walk_addr_o  = row_base_q + ADDR_W'(col_q);
    assign walk_last_o  = active_q && last_s;

    // Next-state for command capture, clip/arm and raster stepping.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        row_base_d = row_base_q;
        active_d   = active_q;
        if (load_i) begin
            x_d = fill_x_i;
            y_d = fill_y_i;
            w_d = fill_w_i;
            h_d = fill_h_i;
        end else if (setup_i) begin
            col_d      = x_q;
            row_d      = y_q;
            x_end_d    = x_end_s;
            y_end_d    = y_end_s;
            row_base_d = ADDR_W'(y_q) * ADDR_W'(WIDTH);
            active_d   = !empty_s;
        end else if (advance_i && active_q) begin
            if (row_end_s) begin
                col_d      = x_q;
                row_d      = row_q + XY_ONE;
                row_base_d = row_base_q + ADDR_W'(WIDTH);
                active_d   = !last_s;
            end else begin
                col_d = col_q + XY_ONE;
            end
        end else begin
            active_d = active_q;
        end
    end

    // Walker state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q        <= XY_ZERO;
            y_q        <= XY_ZERO;
            w_q        <= XY_ZERO;
            h_q        <= XY_ZERO;
            col_q      <= XY_ZERO;
            row_q      <= XY_ZERO;
            x_end_q    <= (XY_W+1)'(0);
            y_end_q    <= (XY_W+1)'(0);
            row_base_q <= ADDR_W'(0);
            active_q   <= 1'b0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            row_base_q <= row_base_d;
            active_q   <= active_d;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner: round-robin between a host pixel stream and
// the rectangle-fill engine, with one registered write stage toward vram.
//  host_valid_i/host_ready_o/host_addr_i/host_data_i : host write stream
//  host_err_o   : 1-cycle pulse after an accepted out-of-range host write
//  fill_start_i + fill_x/y/w/h/color_i : fill command (taken only when idle)
//  fill_busy_o / fill_done_o : fill status
//  fb_we_o / fb_addr_o / fb_data_o : registered vram write port (latency 1)
module fb_write_arbiter
    import fb_write_arbiter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              host_valid_i,
    output logic              host_ready_o,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_data_i,
    output logic              host_err_o,
    input  logic              fill_start_i,
    input  logic [XY_W-1:0]   fill_x_i,
    input  logic [XY_W-1:0]   fill_y_i,
    input  logic [XY_W-1:0]   fill_w_i,
    input  logic [XY_W-1:0]   fill_h_i,
    input  logic [DATA_W-1:0] fill_color_i,
    output logic              fill_busy_o,
    output logic              fill_done_o,
    output logic              fb_we_o,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic [DATA_W-1:0] fb_data_o
);

    fill_state_e       state_q, state_d;
    arb_owner_e        rr_q, rr_d;
    pixel_t            color_q, color_d, fb_data_q, fb_data_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              fb_we_q, fb_we_d, host_err_q, host_err_d;
    logic              fill_busy_q, fill_busy_d, fill_done_q, fill_done_d;

    logic              start_s, fill_req_s, host_ready_s, host_grant_s, fill_grant_s;
    logic              host_in_range_s, empty_s, walk_valid_s, walk_last_s;
    logic [ADDR_W-1:0] walk_addr_s;

    fb_rect_walker u_walker (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (start_s),
        .fill_x_i     (fill_x_i),
        .fill_y_i     (fill_y_i),
        .fill_w_i     (fill_w_i),
        .fill_h_i     (fill_h_i),
        .setup_i      (state_q == ST_SETUP),
        .advance_i    (fill_grant_s),
        .empty_o      (empty_s),
        .walk_valid_o (walk_valid_s),
        .walk_addr_o  (walk_addr_s),
        .walk_last_o  (walk_last_s)
    );

    // host_ready only looks at registered state, never at host_valid.
    assign start_s         = (state_q == ST_IDLE) && fill_start_i;
    assign fill_req_s      = (state_q == ST_FILL) && walk_valid_s;
    assign host_ready_s    = (state_q != ST_FILL) || (rr_q == OWNER_HOST);
    assign host_grant_s    = host_valid_i && host_ready_s;
    assign fill_grant_s    = fill_req_s && (!host_valid_i || (rr_q == OWNER_FILL));
    assign host_in_range_s = host_addr_i < ADDR_W'(FB_PIXELS);

    // Fill FSM, round-robin pointer and write-stage next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start_s ? ST_SETUP : ST_IDLE;
            ST_SETUP: state_d = empty_s ? ST_DONE : ST_FILL;
            ST_FILL:  state_d = (fill_grant_s && walk_last_s) ? ST_DONE : ST_FILL;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        color_d = start_s ? fill_color_i : color_q;

        // Pointer moves to the loser only when both sides contended.
        if (host_valid_i && fill_req_s) begin
            rr_d = (rr_q == OWNER_HOST) ? OWNER_FILL : OWNER_HOST;
        end else begin
            rr_d = rr_q;
        end

        // Idle cycles keep the last address/data on the bus.
        if (fill_grant_s) begin
            fb_we_d   = 1'b1;
            fb_addr_d = walk_addr_s;
            fb_data_d = color_q;
        end else if (host_grant_s && host_in_range_s) begin
            fb_we_d   = 1'b1;
            fb_addr_d = host_addr_i;
            fb_data_d = host_data_i;
        end else begin
            fb_we_d   = 1'b0;
            fb_addr_d = fb_addr_q;
            fb_data_d = fb_data_q;
        end

        host_err_d  = host_grant_s && !host_in_range_s;
        fill_busy_d = (state_d != ST_IDLE);
        fill_done_d = (state_d == ST_DONE);
    end

    // Control and output registers; reset aborts any fill in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rr_q        <= OWNER_HOST;
            color_q     <= DATA_W'(0);
            fb_we_q     <= 1'b0;
            fb_addr_q   <= ADDR_W'(0);
            fb_data_q   <= DATA_W'(0);
            host_err_q  <= 1'b0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            color_q     <= color_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            host_err_q  <= host_err_d;
            fill_busy_q <= fill_busy_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign host_ready_o = host_ready_s;
    assign host_err_o   = host_err_q;
    assign fill_busy_o  = fill_busy_q;
    assign fill_done_o  = fill_done_q;
    assign fb_we_o      = fb_we_q;
    assign fb_addr_o    = fb_addr_q;
    assign fb_data_o    = fb_data_q;

endmodule
